mac_west_feeder: RTL and testbench

West-edge driver for a row-stacked column of `mac_tile` instances. It accepts commands (weight load, execute, OS flush) and per-row data words, builds the 3-bit tile instruction, and drives `inst_w`/`in_w` into every row with a diagonal skew of one cycle per row. The tiles are the receivers of this interface; this block is its transmitter.

---
 rtl/mac_pkg.sv | 39 +++
 rtl/feeder_skew.sv | 31 +++
 rtl/mac_west_feeder.sv | 142 ++++++++++++++
 tb/tb_mac_west_feeder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the mac_tile west-edge feeder: op codes, instruction
// bit layout, controller states and small helpers.
package mac_pkg;

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_EXEC  = 2'b10;
  localparam logic [1:0] OP_FLUSH = 2'b11;

  localparam int INST_MODE = 2;
  localparam int INST_EXEC = 1;
  localparam int INST_LDFL = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // LOAD only makes sense for WS tiles, FLUSH only for OS tiles.
  function automatic logic cmd_is_legal(input logic [1:0] op, input logic mode);
    case (op)
      OP_LOAD:  return !mode;
      OP_EXEC:  return 1'b1;
      OP_FLUSH: return mode;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] make_inst(input logic mode, input logic exec,
                                           input logic ldfl);
    logic [2:0] v;
    v            = '0;
    v[INST_MODE] = mode;
    v[INST_EXEC] = exec;
    v[INST_LDFL] = ldfl;
    return v;
  endfunction

endpackage

// File: rtl/feeder_skew.sv
// Parameterized delay line of DEPTH registers; DEPTH 0 is a plain wire.
module feeder_skew #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic w_unused;
      assign w_unused = clk ^ reset;
      assign o_q      = i_d;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_pipe [DEPTH];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int k = 0; k < DEPTH; k++) r_pipe[k] <= '0;
        end else begin
          r_pipe[0] <= i_d;
          for (int k = 1; k < DEPTH; k++) r_pipe[k] <= r_pipe[k-1];
        end
      end
      assign o_q = r_pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/mac_west_feeder.sv
// West-edge transmitter for a column of mac_tile rows: turns commands and data
// words into skewed per-row inst_w/in_w streams (row r lags row 0 by r cycles).
module mac_west_feeder
  import mac_pkg::*;
#(
  parameter int bw     = 4,
  parameter int row    = 8,
  parameter int len_bw = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic                cmd_mode,
  input  logic [len_bw-1:0]   cmd_len,
  input  logic                data_valid,
  output logic                data_ready,
  input  logic [row*bw-1:0]   data_in,
  output logic [row*bw-1:0]   out_w,
  output logic [row*3-1:0]    inst_w,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int DW = (row > 1) ? $clog2(row) : 1;
  localparam logic [len_bw-1:0] LEN_ONE = len_bw'(1);

  state_t              r_state;
  logic [1:0]          r_op;
  logic                r_mode;
  logic [len_bw-1:0]   r_len;
  logic [len_bw-1:0]   r_cnt;
  logic [DW-1:0]       r_drain;
  logic                r_done;
  logic                r_err;
  logic [2:0]          r_s0_inst;
  logic [row*bw-1:0]   r_s0_data;

  logic w_feeds_data;
  logic w_beat;
  logic w_last;

  assign w_feeds_data = (r_op != OP_FLUSH);
  // FLUSH issues a beat every RUN cycle; LOAD/EXEC only when a word arrives.
  assign w_beat       = (r_state == ST_RUN) && (!w_feeds_data || data_valid);
  assign w_last       = (r_cnt == (r_len - LEN_ONE));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_op      <= '0;
      r_mode    <= 1'b0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_drain   <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_s0_inst <= '0;
      r_s0_data <= '0;
    end else begin
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_s0_inst <= '0;
      r_s0_data <= '0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_op   <= cmd_op;
            r_mode <= cmd_mode;
            r_len  <= cmd_len;
            r_cnt  <= '0;
            if (!cmd_is_legal(cmd_op, cmd_mode)) begin
              r_err <= 1'b1;
            end else if (cmd_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (!w_feeds_data) begin
            r_s0_inst <= make_inst(1'b1, 1'b0, 1'b1);
          end else if (data_valid) begin
            r_s0_inst <= (r_op == OP_LOAD) ? make_inst(1'b0, 1'b0, 1'b1)
                                           : make_inst(r_mode, 1'b1, 1'b0);
            r_s0_data <= data_in;
          end else begin
            r_s0_inst <= make_inst(r_mode, 1'b0, 1'b0);
          end
          if (w_beat) begin
            r_cnt <= r_cnt + LEN_ONE;
            if (w_last) begin
              if (row > 1) begin
                r_state <= ST_DRAIN;
                r_drain <= DW'(row - 1);
              end else begin
                r_state <= ST_IDLE;
                r_done  <= 1'b1;
              end
            end
          end
        end
        ST_DRAIN: begin
          r_s0_inst <= make_inst(r_mode, 1'b0, 1'b0);
          r_drain   <= r_drain - DW'(1);
          if (r_drain == DW'(1)) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign data_ready = (r_state == ST_RUN) && w_feeds_data;
  assign done       = r_done;
  assign err        = r_err;

  generate
    for (genvar gi = 0; gi < row; gi++) begin : g_row
      logic [bw+2:0] w_skew_out;
      feeder_skew #(
        .WIDTH (bw + 3),
        .DEPTH (gi)
      ) u_skew (
        .clk   (clk),
        .reset (reset),
        .i_d   ({r_s0_inst, r_s0_data[gi*bw +: bw]}),
        .o_q   (w_skew_out)
      );
      assign inst_w[gi*3 +: 3]  = w_skew_out[bw +: 3];
      assign out_w[gi*bw +: bw] = w_skew_out[bw-1:0];
    end
  endgenerate

endmodule

// File: tb/tb_mac_west_feeder.sv
// Directed + random bench: a cycle-indexed timeline of what row 0 should show,
// with row r expected to show row 0's value from r cycles earlier.
module tb_mac_west_feeder;

  localparam int BW   = 4;
  localparam int ROW  = 8;
  localparam int LB   = 8;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_mode = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [LB-1:0] cmd_len = '0;
  logic data_valid = 1'b0;
  logic [ROW*BW-1:0] data_in = '0;
  logic cmd_ready, data_ready, busy, done, err;
  logic [ROW*BW-1:0] out_w;
  logic [ROW*3-1:0] inst_w;

  mac_west_feeder #(.bw(BW), .row(ROW), .len_bw(LB)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_mode   (cmd_mode),
    .cmd_len    (cmd_len),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_in    (data_in),
    .out_w      (out_w),
    .inst_w     (inst_w),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int rst_cyc = -1;
  int errs = 0;
  int checks = 0;

  // Timeline model: row-0 contents and control outputs per absolute cycle.
  bit [2:0]        m_inst   [MAXC];
  bit [ROW*BW-1:0] m_data   [MAXC];
  bit              m_busy   [MAXC];
  bit              m_dready [MAXC];
  bit              m_done   [MAXC];
  bit              m_err    [MAXC];
  logic [ROW*BW-1:0] dq [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errs++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, expv);
    end
  endtask

  task automatic check_cycle();
    int c, s;
    logic [2:0] ei;
    logic [BW-1:0] ed;
    c = cyc;
    for (int r = 0; r < ROW; r++) begin
      s = c - r;
      if (s > rst_cyc) begin
        ei = m_inst[s];
        ed = m_data[s][r*BW +: BW];
      end else begin
        ei = '0;
        ed = '0;
      end
      chk($sformatf("inst_w[%0d]", r), 32'(inst_w[r*3 +: 3]), 32'(ei));
      chk($sformatf("out_w[%0d]", r), 32'(out_w[r*BW +: BW]), 32'(ed));
    end
    chk("busy", 32'(busy), 32'(m_busy[c]));
    chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy[c]));
    chk("data_ready", 32'(data_ready), 32'(m_dready[c]));
    chk("done", 32'(done), 32'(m_done[c]));
    chk("err", 32'(err), 32'(m_err[c]));
  endtask

  task automatic tick();
    @(negedge clk);
    if (rst_cyc >= 0) check_cycle();
    @(posedge clk);
    if (reset) begin
      rst_cyc = cyc;
      for (int i = cyc + 1; i < MAXC; i++) begin
        m_inst[i] = '0; m_data[i] = '0; m_busy[i] = 1'b0;
        m_dready[i] = 1'b0; m_done[i] = 1'b0; m_err[i] = 1'b0;
      end
    end
    cyc++;
    if (cyc >= MAXC - 64) begin
      errs++;
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC - 64);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $fatal(1, "cycle budget exhausted");
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cmd_valid  = 1'b0;
      data_valid = 1'($urandom_range(0, 1));
      data_in    = $urandom();
      tick();
    end
    data_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic mode, input int len,
                         input int vprob, input int pre);
    int a, c, t, nb, k;
    bit legal, dv;
    logic [ROW*BW-1:0] w;
    a = cyc;
    legal = !(op == 2'b00 || (op == 2'b01 && mode) || (op == 2'b11 && !mode));
    cmd_valid = 1'b1; cmd_op = op; cmd_mode = mode; cmd_len = LB'(len);
    data_valid = 1'b0;
    if (!legal) m_err[a+1] = 1'b1;
    else if (len == 0) m_done[a+1] = 1'b1;
    $display("cmd op=%0d mode=%0d len=%0d legal=%0d issued at cycle %0d", op, mode, len, legal, a);
    tick();
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom_range(0, 3));
    if (!legal || len == 0) begin
      dq.delete();
      return;
    end
    nb = 0;
    k  = 0;
    while (nb < len) begin
      c = cyc;
      m_busy[c] = 1'b1;
      w = $urandom();
      if (op == 2'b11) begin
        data_valid = 1'($urandom_range(0, 1));
        data_in    = w;
        m_inst[c+1] = 3'b101;
        m_data[c+1] = '0;
        nb++;
      end else begin
        m_dready[c] = 1'b1;
        dv = (k >= pre) && ($urandom_range(0, 99) < vprob);
        if (dv && dq.size() > 0) w = dq.pop_front();
        data_valid = dv;
        data_in    = w;
        if (dv) begin
          m_inst[c+1] = (op == 2'b01) ? 3'b001 : {mode, 2'b10};
          m_data[c+1] = w;
          nb++;
        end else begin
          m_inst[c+1] = {mode, 2'b00};
          m_data[c+1] = '0;
        end
      end
      k++;
      tick();
    end
    data_valid = 1'b0;
    t = cyc - 1;
    for (int d = 1; d < ROW; d++) begin
      m_busy[t+d]   = 1'b1;
      m_inst[t+d+1] = {mode, 2'b00};
      m_data[t+d+1] = '0;
    end
    m_done[t+ROW] = 1'b1;
  endtask

  initial begin
    logic [1:0] rop;
    reset = 1'b1;
    tick(); tick(); tick();
    reset = 1'b0;
    idle(2);

    // WS LOAD len 2: all rows 3, then all rows 5
    dq.push_back({ROW{4'h3}});
    dq.push_back({ROW{4'h5}});
    run_cmd(2'b01, 1'b0, 2, 100, 0);
    idle(ROW + 1);

    // WS EXEC len 1 with two leading bubbles, row 0 data 2
    dq.push_back(32'h0000_0002);
    run_cmd(2'b10, 1'b0, 1, 100, 2);
    idle(ROW + 1);

    // OS EXEC len 3 then FLUSH issued on the done cycle
    dq.push_back({ROW{4'h4}});
    dq.push_back({ROW{4'h1}});
    dq.push_back({ROW{4'h1}});
    run_cmd(2'b10, 1'b1, 3, 100, 0);
    idle(ROW - 1);
    run_cmd(2'b11, 1'b1, 2, 100, 0);
    idle(ROW + 1);

    // Illegal commands
    run_cmd(2'b11, 1'b0, 3, 100, 0);
    idle(3);
    run_cmd(2'b00, 1'b0, 2, 100, 0);
    idle(2);
    run_cmd(2'b01, 1'b1, 2, 100, 0);
    idle(2);

    // Zero-length EXEC
    run_cmd(2'b10, 1'b0, 0, 100, 0);
    idle(3);

    // Reset while draining
    run_cmd(2'b01, 1'b0, 3, 100, 0);
    idle(2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle(ROW + 2);

    // Random commands
    for (int n = 0; n < 25; n++) begin
      rop = 2'($urandom_range(0, 3));
      run_cmd(rop, 1'($urandom_range(0, 1)), $urandom_range(0, 6),
              $urandom_range(30, 100), $urandom_range(0, 2));
      idle(ROW - 1 + $urandom_range(0, 2));
    end
    idle(ROW + 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
